// File: rtl/yuv2rgb_stream.sv
// Streaming YUV 4:4:4 / 4:2:2 to RGB converter: a byte collector FSM feeds a
// two-stage product/sum pipeline with valid/ready handshakes on both ends.
module yuv2rgb_stream #(
  parameter int DATA_W  = 8,
  parameter int FRAC_W  = 4,
  parameter int COEF_W  = 8,
  parameter int COEF_RV = 26,
  parameter int COEF_GU = 4,
  parameter int COEF_GV = 12,
  parameter int COEF_BU = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fmt_422,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fmt_err
);

  localparam int PW = DATA_W + COEF_W + 3;

  localparam logic signed [PW-1:0] K_RV = PW'(COEF_RV);
  localparam logic signed [PW-1:0] K_GU = PW'(COEF_GU);
  localparam logic signed [PW-1:0] K_GV = PW'(COEF_GV);
  localparam logic signed [PW-1:0] K_BU = PW'(COEF_BU);
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC_W - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** DATA_W - 1);

  typedef enum logic [2:0] {C_Y, C_U, C_V, C_Y0, C_Y1} col_state_t;

  col_state_t        state;
  logic              mode_422;
  logic              ready_en;
  logic              accept;
  logic              first_state;
  logic              pix_done;
  logic              s2_en;
  logic              s1_valid;
  logic [DATA_W-1:0] y_reg, u_reg, v_reg;
  logic [DATA_W-1:0] pix_y, pix_u, pix_v;

  logic signed [PW-1:0] ys_n, p_rv_n, p_gu_n, p_gv_n, p_bu_n;
  logic signed [PW-1:0] s1_ys, s1_rv, s1_gu, s1_gv, s1_bu;

  function automatic logic signed [PW-1:0] sext(input logic [DATA_W-1:0] x);
    return {{(PW-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Round half up, drop the fraction, then saturate into [0, 2^DATA_W-1].
  function automatic logic [DATA_W-1:0] round_clamp(input logic signed [PW-1:0] acc);
    logic signed [PW-1:0] q;
    q = (acc + RND) >>> FRAC_W;
    if (q[PW-1])
      return '0;
    else if (q > MAXV)
      return '1;
    else
      return q[DATA_W-1:0];
  endfunction

  assign s2_en       = !out_valid || out_ready;
  assign in_ready    = ready_en && (!s1_valid || s2_en);
  assign accept      = in_valid && in_ready;
  assign first_state = mode_422 ? (state == C_U) : (state == C_Y);
  assign pix_done    = accept && !in_sof &&
                       ((state == C_V) || (mode_422 && (state == C_Y1)));

  // The completing beat supplies its own component straight from in_data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pix_y = y_reg;
    pix_u = u_reg;
    pix_v = in_data;
    if (state == C_Y1) begin
      pix_y = in_data;
      pix_v = v_reg;
    end
  end

  assign ys_n   = {{(PW-DATA_W-FRAC_W){1'b0}}, pix_y, {FRAC_W{1'b0}}};
  assign p_rv_n = sext(pix_v) * K_RV;
  assign p_gu_n = sext(pix_u) * K_GU;
  assign p_gv_n = sext(pix_v) * K_GV;
  assign p_bu_n = sext(pix_u) * K_BU;

  // Collector FSM: advances only on accepted beats; SOF restarts the group.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state    <= C_Y;
      mode_422 <= 1'b0;
      fmt_err  <= 1'b0;
      ready_en <= 1'b0;
      y_reg    <= '0;
      u_reg    <= '0;
      v_reg    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (in_sof) begin
          mode_422 <= fmt_422;
          if (!first_state)
            fmt_err <= 1'b1;
          if (fmt_422) begin
            u_reg <= in_data;
            state <= C_Y0;
          end else begin
            y_reg <= in_data;
            state <= C_U;
          end
        end else begin
          case (state)
            C_Y: begin
              y_reg <= in_data;
              state <= C_U;
            end
            C_U: begin
              u_reg <= in_data;
              state <= mode_422 ? C_Y0 : C_V;
            end
            C_Y0: begin
              y_reg <= in_data;
              state <= C_V;
            end
            C_V: begin
              v_reg <= in_data;
              state <= mode_422 ? C_Y1 : C_Y;
            end
            C_Y1:    state <= C_U;
            default: state <= C_Y;
          endcase
        end
      end
    end
  end

  // S1: product register; refills whenever it is empty or draining into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so outputs read 0 after reset.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ys    <= '0;
      s1_rv    <= '0;
      s1_gu    <= '0;
      s1_gv    <= '0;
      s1_bu    <= '0;
    end else if (!s1_valid || s2_en) begin
      s1_valid <= pix_done;
      if (pix_done) begin
        s1_ys <= ys_n;
        s1_rv <= p_rv_n;
        s1_gu <= p_gu_n;
        s1_gv <= p_gv_n;
        s1_bu <= p_bu_n;
      end
    end
  end

  // S2: output register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_r <= round_clamp(s1_ys + s1_rv);
        out_g <= round_clamp(s1_ys - s1_gu - s1_gv);
        out_b <= round_clamp(s1_ys + s1_bu);
      end
    end
  end

endmodule

// File: tb/tb_yuv2rgb_stream.sv
// Self-checking bench for yuv2rgb_stream: directed cases plus random pixels
// scored against an integer colour-conversion model and an expected-pixel queue.
module tb_yuv2rgb_stream;

  localparam int FRAC_W  = 4;
  localparam int COEF_RV = 26;
  localparam int COEF_GU = 4;
  localparam int COEF_GV = 12;
  localparam int COEF_BU = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fmt_422;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_r, out_g, out_b;
  logic       out_valid;
  logic       out_ready;
  logic       fmt_err;

  int checks = 0;
  int errors = 0;
  int px_idx = 0;
  logic [23:0] exp_q[$];

  yuv2rgb_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fmt_422   (fmt_422),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fmt_err   (fmt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  // Plain integer form of the conversion equations with round-half-up.
  function automatic logic [23:0] ref_rgb(input int y, input int u, input int v);
    int su, sv, ys, half, r, g, b;
    su   = (u > 127) ? u - 256 : u;
    sv   = (v > 127) ? v - 256 : v;
    ys   = y * (1 << FRAC_W);
    half = 1 << (FRAC_W - 1);
    r = clamp8((ys + COEF_RV * sv + half) >>> FRAC_W);
    g = clamp8((ys - COEF_GU * su - COEF_GV * sv + half) >>> FRAC_W);
    b = clamp8((ys + COEF_BU * su + half) >>> FRAC_W);
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // Scoreboard: every valid output must match the head of the expected queue;
  // the head is only retired on a handshake, so a stalled pixel must hold.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_pixel", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        check($sformatf("pixel%0d", px_idx), {8'd0, out_r, out_g, out_b}, {8'd0, exp_q[0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          px_idx++;
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic sof);
    int  waited;
    bit  took;
    waited   = 0;
    took     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (!took && waited > 200) begin
        check("beat_timeout", 32'(took), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_444(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                          input bit sof, input logic [23:0] e);
    exp_q.push_back(e);
    if (sof) fmt_422 = 1'b0;
    drive_beat(y, sof);
    drive_beat(u, 1'b0);
    drive_beat(v, 1'b0);
  endtask

  task automatic send_422(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                          input logic [7:0] y1, input bit sof,
                          input logic [23:0] e0, input logic [23:0] e1);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    if (sof) fmt_422 = 1'b1;
    drive_beat(u, sof);
    drive_beat(y0, 1'b0);
    drive_beat(v, 1'b0);
    drive_beat(y1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_rand_444(input bit sof);
    logic [7:0] y, u, v;
    y = 8'($urandom);
    u = 8'($urandom);
    v = 8'($urandom);
    send_444(y, u, v, sof, ref_rgb(int'(y), int'(u), int'(v)));
  endtask

  initial begin
    bit saw_ready_low;
    logic [7:0] u, y0, v, y1;

    rst_n     = 1'b0;
    fmt_422   = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #22;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // 4:4:4 basic with latency
    send_444(8'd100, 8'h00, 8'h10, 1'b1, {8'd126, 8'd88, 8'd100});
    check("latency_edge1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_edge2", 32'(out_valid), 32'd1);
    drain("drain_basic");

    // Saturation and rounding
    send_444(8'd100, 8'h80, 8'h00, 1'b0, {8'd100, 8'd132, 8'd0});
    send_444(8'd200, 8'h64, 8'h00, 1'b0, ref_rgb(200, 100, 0));
    send_444(8'd10,  8'h00, 8'h01, 1'b0, {8'd12, 8'd9, 8'd10});
    drain("drain_sat");
    check("sat_b_255", 32'(ref_rgb(200, 100, 0) & 24'h0000ff), 32'd255);

    // 4:2:2 pair, then random 4:2:2 groups
    send_422(8'h08, 8'd50, 8'h04, 8'd60, 1'b1,
             {8'd57, 8'd45, 8'd66}, {8'd67, 8'd55, 8'd76});
    for (int i = 0; i < 4; i++) begin
      u  = 8'($urandom);
      y0 = 8'($urandom);
      v  = 8'($urandom);
      y1 = 8'($urandom);
      send_422(u, y0, v, y1, 1'b0, ref_rgb(int'(y0), int'(u), int'(v)),
               ref_rgb(int'(y1), int'(u), int'(v)));
    end
    drain("drain_422");

    // Back to 4:4:4 via SOF, random pixels
    send_rand_444(1'b1);
    for (int i = 0; i < 4; i++) send_rand_444(1'b0);
    drain("drain_444_rand");

    // Backpressure: 6 back-to-back pixels with a 5-cycle stall mid-stream
    saw_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand_444(1'b0);
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!in_ready) saw_ready_low = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_dropped", 32'(saw_ready_low), 32'd1);
    drain("drain_backpressure");

    // Resync: SOF arrives on what would be the V beat
    check("fmt_err_clear", 32'(fmt_err), 32'd0);
    fmt_422 = 1'b0;
    drive_beat(8'd30, 1'b1);
    drive_beat(8'h20, 1'b0);
    send_444(8'd80, 8'hF0, 8'h30, 1'b1, ref_rgb(80, 16'hF0, 16'h30));
    drain("drain_resync");
    check("fmt_err_set", 32'(fmt_err), 32'd1);
    send_rand_444(1'b0);
    drain("drain_after_resync");
    check("fmt_err_sticky", 32'(fmt_err), 32'd1);

    // Reset mid-stream with pixels in S1 and S2 while in 4:2:2 mode
    out_ready = 1'b0;
    send_422(8'h10, 8'd20, 8'h20, 8'd40, 1'b1, ref_rgb(20, 16, 32), ref_rgb(40, 16, 32));
    @(negedge clk);
    check("midrst_out_valid_pre", 32'(out_valid), 32'd1);
    check("midrst_in_ready_pre", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid_async", 32'(out_valid), 32'd0);
    check("midrst_fmt_err_cleared", 32'(fmt_err), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(out_valid), 32'd0);
    fmt_422 = 1'b1;
    send_444(8'd90, 8'h05, 8'hFB, 1'b0, ref_rgb(90, 5, 16'hFB));
    drain("drain_mode_restored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
